// File: rtl/cursor_ctrl.sv
// Grid cursor controller: button press/hold auto-repeat moves a working position,
// which is committed to the outputs once per frame on the vsync falling edge.
//
// state  | meaning
// IDLE   | no direction held, or a held direction has already been released
// HOLD   | first step taken, counting down the initial hold delay
// REPEAT | hold delay expired, stepping once per repeat period
module cursor_ctrl #(
  parameter int LOG_HOLD_COUNT   = 23,
  parameter int LOG_REPEAT_COUNT = 20,
  parameter int GRID_W           = 80,
  parameter int GRID_H           = 60,
  parameter int POS_W            = 10
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             btnu_in,
  input  logic             btnd_in,
  input  logic             btnl_in,
  input  logic             btnr_in,
  input  logic             btnc_in,
  input  logic             vsync_in,
  output logic [POS_W-1:0] cursor_x_out,
  output logic [POS_W-1:0] cursor_y_out,
  output logic             click_out,
  output logic             moved_out
);

  localparam int CNT_W = (LOG_HOLD_COUNT > LOG_REPEAT_COUNT) ? LOG_HOLD_COUNT : LOG_REPEAT_COUNT;
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'((64'd1 << LOG_HOLD_COUNT) - 64'd1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'((64'd1 << LOG_REPEAT_COUNT) - 64'd1);
  localparam logic [POS_W-1:0] X_MAX  = POS_W'(GRID_W - 1);
  localparam logic [POS_W-1:0] Y_MAX  = POS_W'(GRID_H - 1);
  localparam logic [POS_W-1:0] X_INIT = POS_W'(GRID_W / 2);
  localparam logic [POS_W-1:0] Y_INIT = POS_W'(GRID_H / 2);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dir;
  logic [3:0]       dir_prev;
  logic             dir_changed;
  logic [POS_W-1:0] work_x;
  logic [POS_W-1:0] work_y;
  logic [POS_W-1:0] step_x;
  logic [POS_W-1:0] step_y;
  logic             btnc_prev;
  logic             vs_prev;
  logic             vs_fall;
  logic             click_rise;

  // Opposing buttons cancel; otherwise move one cell with wrap at both ends.
  function automatic logic [POS_W-1:0] wrap_step(
    input logic [POS_W-1:0] pos,
    input logic             inc,
    input logic             dec,
    input logic [POS_W-1:0] max_pos
  );
    logic [POS_W-1:0] res;
    res = pos;
    if (inc && !dec) begin
      res = (pos == max_pos) ? '0 : pos + POS_W'(1);
    end else if (dec && !inc) begin
      res = (pos == '0) ? max_pos : pos - POS_W'(1);
    end
    return res;
  endfunction

  assign dir         = {btnu_in, btnd_in, btnl_in, btnr_in};
  assign dir_changed = (dir != dir_prev);
  assign vs_fall     = vs_prev && !vsync_in;
  assign click_rise  = btnc_in && !btnc_prev;

  always_comb begin
    step_x = wrap_step(work_x, btnr_in, btnl_in, X_MAX);
    step_y = wrap_step(work_y, btnd_in, btnu_in, Y_MAX);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      dir_prev     <= '0;
      work_x       <= X_INIT;
      work_y       <= Y_INIT;
      cursor_x_out <= X_INIT;
      cursor_y_out <= Y_INIT;
      click_out    <= 1'b0;
      moved_out    <= 1'b0;
      btnc_prev    <= 1'b0;
      vs_prev      <= 1'b1;
    end else begin
      dir_prev  <= dir;
      btnc_prev <= btnc_in;
      vs_prev   <= vsync_in;
      click_out <= click_rise;

      // Commit samples work_x/work_y before any same-cycle step lands.
      if (vs_fall) begin
        cursor_x_out <= work_x;
        cursor_y_out <= work_y;
        moved_out    <= (work_x != cursor_x_out) || (work_y != cursor_y_out);
      end else begin
        moved_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (dir_changed && (dir != 4'b0000)) begin
            work_x <= step_x;
            work_y <= step_y;
            cnt    <= HOLD_LOAD;
            state  <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (dir_changed) begin
            if (dir == 4'b0000) begin
              state <= IDLE;
            end else begin
              work_x <= step_x;
              work_y <= step_y;
              cnt    <= HOLD_LOAD;
              state  <= HOLD;
            end
          end else if (cnt == '0) begin
            work_x <= step_x;
            work_y <= step_y;
            cnt    <= REPEAT_LOAD;
            state  <= REPEAT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 Parameter LOG_HOLD_COUNT, default 23; the initial hold delay before auto-repeat is 2^LOG_HOLD_COUNT cycles.
REQ-002 Parameter LOG_REPEAT_COUNT, default 20; the auto-repeat period is 2^LOG_REPEAT_COUNT cycles.
REQ-003 Parameter GRID_W, default 80; the number of cursor columns.
REQ-004 Parameter GRID_H, default 60; the number of cursor rows.
REQ-005 Parameter POS_W, default 10; the bit width of the position outputs, with GRID_W and GRID_H both <= 2^POS_W.
REQ-006 clk_in  input  1  system clock; all logic SHALL be on its rising edge.
REQ-007 rst_in  input  1  synchronous active-high reset.
REQ-008 btnu_in, btnd_in, btnl_in, btnr_in  input  1 each  debounced, level-high direction buttons.
REQ-009 btnc_in  input  1  debounced, level-high select button.
REQ-010 vsync_in  input  1  VGA vertical sync, active-low.
REQ-011 cursor_x_out  output  POS_W  committed column, 0..GRID_W-1.
REQ-012 cursor_y_out  output  POS_W  committed row, 0..GRID_H-1.
REQ-013 click_out  output  1  one-cycle select pulse.
REQ-014 moved_out  output  1  one-cycle pulse when the committed position changes.

Function
REQ-015 dir = {btnu_in, btnd_in, btnl_in, btnr_in} SHALL be registered once per cycle as dir_prev, and the block SHALL act on the change dir != dir_prev.
REQ-016 A step SHALL set work_x += (r - l) and work_y += (d - u); opposite buttons cancel, giving no motion on that axis.
REQ-017 Step arithmetic SHALL wrap: work_x at GRID_W-1 stepping +1 goes to 0, and at 0 stepping -1 goes to GRID_W-1; work_y behaves the same using GRID_H.
REQ-018 The FSM SHALL have three states: IDLE, HOLD and REPEAT, with a single down-counter shared between HOLD and REPEAT.
REQ-019 In IDLE, if dir != 0 and dir != dir_prev, the block SHALL step in the same cycle, load the counter with 2^LOG_HOLD_COUNT-1, and go to HOLD.
REQ-020 In HOLD or REPEAT, if dir changes to 0, the block SHALL go to IDLE with no step.
REQ-021 In HOLD or REPEAT, if dir changes to a different nonzero value, the block SHALL step, reload the counter with the HOLD value, and go to HOLD.
REQ-022 In HOLD with dir unchanged, when the counter is 0 the block SHALL step, load 2^LOG_REPEAT_COUNT-1, and go to REPEAT; otherwise it SHALL decrement the counter.
REQ-023 In REPEAT with dir unchanged, when the counter is 0 the block SHALL step and reload 2^LOG_REPEAT_COUNT-1; otherwise it SHALL decrement the counter.
REQ-024 Steps in REQ-019..023 SHALL update work_x/work_y on the next clock edge, i.e. one cycle after the triggering input is sampled.
REQ-025 A vsync falling edge SHALL be detected from a registered vsync_in (vs_prev=1, vsync_in=0).
REQ-026 On the cycle after a detected falling edge, cursor_x_out/cursor_y_out SHALL load work_x/work_y; at no other time SHALL they change except on reset.
REQ-027 moved_out SHALL be 1 on the same cycle cursor outputs load, if and only if the loaded value differs from the previous committed value.
REQ-028 If a step and a commit occur in the same cycle, the commit SHALL take the pre-step work value, and the step SHALL appear at the next commit.
REQ-029 On a btnc_in rising edge (btnc_in=1, btnc_prev=0), click_out SHALL be 1 on the next cycle only; click_out SHALL NOT be gated by vsync.
REQ-030 Holding btnc_in SHALL NOT produce further click_out pulses.
REQ-031 click_out SHALL be independent of direction activity; simultaneous press events SHALL both take effect.

Reset
REQ-032 While rst_in is sampled 1: state = IDLE; counter = 0; work_x = cursor_x_out = GRID_W/2; work_y = cursor_y_out = GRID_H/2; click_out = 0; moved_out = 0; dir_prev = 0; btnc_prev = 0; vs_prev = 1.
REQ-033 Reset SHALL take priority over all events in the same cycle and SHALL abort any HOLD or REPEAT in progress.
REQ-034 A button held through reset release SHALL be treated as a new press on the first cycle after reset.

Verification (LOG_HOLD_COUNT=3, LOG_REPEAT_COUNT=2, GRID_W=8, GRID_H=6)
REQ-035 Reset, then one vsync low pulse -> cursor = (4,3) and moved_out never pulses.
REQ-036 Press btnr for 1 cycle, then release, then a vsync pulse -> work_x = 5; on the commit cycle cursor_x = 5 and moved_out = 1 for one cycle.
REQ-037 Hold btnr for 30 cycles from x=4 -> steps at cycle 0, at +8 (end of HOLD), then every 4 cycles: 7 steps, so x wraps to 3; x sequence 5,6,7,0,1,2,3.
REQ-038 Press btnl and btnu together at (0,0) -> work = (7,5); press btnl+btnr together -> x unchanged and y unchanged.
REQ-039 Hold btnc for 10 cycles -> exactly one click_out pulse, 1 cycle after the rise; the same holds with btnd pressed in the same cycle, which also steps y.
REQ-040 Assert rst_in mid-REPEAT while btnr is held -> outputs return to (4,3); after release of rst_in, x steps to 5 one cycle later and HOLD timing restarts.
